// File: rtl/multiway_traffic_controller_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared encodings for the multiway traffic controller:
//   lamp_t  - 2-bit lamp code driven per direction (RED/GREEN/YELLOW)
//   phase_t - controller phase state
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } lamp_t;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10,
    PH_WALK   = 2'b11
  } phase_t;

endpackage

// File: rtl/multiway_traffic_controller_if.sv
// -----------------------------------------------------------------------------
// multiway_traffic_controller_if
// Request/lamp bundle between the intersection environment and the controller.
//   car_req    [NUM_DIR]   per-direction vehicle sensors
//   ped_req                pedestrian button
//   lights     [2*NUM_DIR] lamp code for dir i on bits [2i+1:2i]
//   active_dir [DIR_W]     direction currently green/yellow
//   walk                   pedestrian walk indication
// Modports: master = environment (drives requests), slave = controller.
// -----------------------------------------------------------------------------
interface multiway_traffic_controller_if #(
  parameter int NUM_DIR = 4
);
  localparam int DIR_W = $clog2(NUM_DIR);

  logic [NUM_DIR-1:0]   car_req;
  logic                 ped_req;
  logic [2*NUM_DIR-1:0] lights;
  logic [DIR_W-1:0]     active_dir;
  logic                 walk;

  modport master (
    output car_req, ped_req,
    input  lights, active_dir, walk
  );

  modport slave (
    input  car_req, ped_req,
    output lights, active_dir, walk
  );
endinterface

// File: rtl/multiway_traffic_controller_rr_next_dir.sv
// -----------------------------------------------------------------------------
// rr_next_dir
// Combinational round-robin picker. Returns the first pending direction found
// searching upward from i_cur+1 with wrap-around (i_cur itself is the last
// candidate). With nothing pending it returns (i_cur+1) mod NUM_DIR.
//   i_pending [NUM_DIR]  latched requests
//   i_cur     [DIR_W]    current direction
//   o_next    [DIR_W]    selected next direction
// -----------------------------------------------------------------------------
module rr_next_dir
  import traffic_pkg::*;
#(
  parameter int NUM_DIR = 4,
  parameter int DIR_W   = 2
) (
  input  logic [NUM_DIR-1:0] i_pending,
  input  logic [DIR_W-1:0]   i_cur,
  output logic [DIR_W-1:0]   o_next
);

  // Scan from the farthest offset down to the nearest so the nearest
  // pending direction is the one left standing.
  always_comb begin
    int idx;
    idx    = (int'(i_cur) + 1) % NUM_DIR;
    o_next = DIR_W'(idx);
    for (int k = NUM_DIR; k >= 1; k--) begin
      idx = (int'(i_cur) + k) % NUM_DIR;
      if (i_pending[idx]) begin
        o_next = DIR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/multiway_traffic_controller.sv
// -----------------------------------------------------------------------------
// multiway_traffic_controller
// N-direction traffic-light controller: sensor-driven round-robin phase
// selection, min/max green, fixed yellow and all-red clearance, optional
// pedestrian walk phase.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    multiway_traffic_controller_if.slave (requests in, lamps out)
// Build option: define PED_WALK_EN to latch ped_req and insert the WALK phase
// after ALLRED. Without it ped_req is ignored and walk is held at 0.
// -----------------------------------------------------------------------------
module multiway_traffic_controller
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = 4,
  parameter int GREEN_MIN  = 3,
  parameter int GREEN_MAX  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 4,
  parameter int TIMER_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  multiway_traffic_controller_if.slave bus
);

  localparam int DIR_W = $clog2(NUM_DIR);

  phase_t               r_state,   w_state_next;
  logic [TIMER_W-1:0]   r_timer,   w_timer_next;
  logic [DIR_W-1:0]     r_dir,     w_dir_next;
  logic [NUM_DIR-1:0]   r_pending, w_pending_next;
  logic                 r_ped,     w_ped_next;
  logic [DIR_W-1:0]     w_rr_dir;
  logic [NUM_DIR-1:0]   w_dir_mask;
  logic                 w_others;
  logic                 w_enter;

  assign w_dir_mask = NUM_DIR'(1) << r_dir;
  assign w_others   = |(r_pending & ~w_dir_mask);

  rr_next_dir #(
    .NUM_DIR (NUM_DIR),
    .DIR_W   (DIR_W)
  ) u_rr (
    .i_pending (r_pending),
    .i_cur     (r_dir),
    .o_next    (w_rr_dir)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= PH_GREEN;
      r_timer   <= '0;
      r_dir     <= '0;
      r_pending <= '0;
      r_ped     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_dir     <= w_dir_next;
      r_pending <= w_pending_next;
      r_ped     <= w_ped_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dir_next   = r_dir;
    w_enter      = 1'b0;

    case (r_state)
      PH_GREEN: begin
        // Early exit once minimum green is served and someone else waits.
        if ((r_timer == TIMER_W'(GREEN_MAX - 1)) ||
            ((r_timer >= TIMER_W'(GREEN_MIN - 1)) && (w_others || r_ped))) begin
          w_state_next = PH_YELLOW;
          w_enter      = 1'b1;
        end
      end
      PH_YELLOW: begin
        if (r_timer == TIMER_W'(YELLOW_CYC - 1)) begin
          w_state_next = PH_ALLRED;
          w_enter      = 1'b1;
        end
      end
      PH_ALLRED: begin
        if (r_timer == TIMER_W'(ALLRED_CYC - 1)) begin
          w_enter = 1'b1;
          if (r_ped) begin
            w_state_next = PH_WALK;
          end else begin
            w_state_next = PH_GREEN;
            w_dir_next   = w_rr_dir;
          end
        end
      end
      default: begin // PH_WALK
        if (r_timer == TIMER_W'(WALK_CYC - 1)) begin
          w_state_next = PH_GREEN;
          w_dir_next   = w_rr_dir;
          w_enter      = 1'b1;
        end
      end
    endcase

    w_timer_next = w_enter ? '0 : r_timer + 1'b1;

    // The green direction's own sensor is masked; entering green clears the
    // served bit even if a new request lands on the same edge.
    w_pending_next = r_pending |
                     (bus.car_req & ~((r_state == PH_GREEN) ? w_dir_mask : '0));
    if (w_enter && (w_state_next == PH_GREEN)) begin
      w_pending_next = w_pending_next & ~(NUM_DIR'(1) << w_dir_next);
    end

`ifdef PED_WALK_EN
    w_ped_next = r_ped | (bus.ped_req && (r_state != PH_WALK));
    if (w_enter && (w_state_next == PH_WALK)) begin
      w_ped_next = 1'b0;
    end
`else
    w_ped_next = 1'b0;
`endif
  end

`ifndef PED_WALK_EN
  logic w_unused_ped;
  assign w_unused_ped = bus.ped_req;
`endif

  for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
    assign bus.lights[2*gi +: 2] =
      (r_dir != DIR_W'(gi))     ? RED    :
      (r_state == PH_GREEN)     ? GREEN  :
      (r_state == PH_YELLOW)    ? YELLOW : RED;
  end

  assign bus.active_dir = r_dir;

`ifdef PED_WALK_EN
  assign bus.walk = (r_state == PH_WALK);
`else
  assign bus.walk = 1'b0;
`endif

endmodule

// File: tb/tb_multiway_traffic_controller.sv
// -----------------------------------------------------------------------------
// tb_multiway_traffic_controller
// Directed scenarios for the key timing points, then randomized requests and
// resets, all compared every cycle against a phase-level reference model.
// -----------------------------------------------------------------------------
module tb_multiway_traffic_controller;

  localparam int N    = 4;
  localparam int GMIN = 3;
  localparam int GMAX = 8;
  localparam int YC   = 2;
  localparam int ARC  = 1;
  localparam int WC   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multiway_traffic_controller_if #(.NUM_DIR(N)) bus ();

  multiway_traffic_controller #(
    .NUM_DIR    (N),
    .GREEN_MIN  (GMIN),
    .GREEN_MAX  (GMAX),
    .YELLOW_CYC (YC),
    .ALLRED_CYC (ARC),
    .WALK_CYC   (WC),
    .TIMER_W    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;

  // Reference model: phase 0=green 1=yellow 2=allred 3=walk, age = cycles spent.
  int m_phase, m_dir, m_age, m_ped, last_phase;
  bit m_pend [N];
  string pname [4] = '{"GREEN", "YELLOW", "ALLRED", "WALK"};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_no, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_dir = 0; m_age = 0; m_ped = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endfunction

  function automatic int pick_next();
    for (int k = 1; k <= N; k++)
      if (m_pend[(m_dir + k) % N]) return (m_dir + k) % N;
    return (m_dir + 1) % N;
  endfunction

  function automatic void model_step(input logic [N-1:0] car, input logic ped);
    int done  = m_age + 1;
    bit others = 1'b0;
    bit leave  = 1'b0;
    bit pend_n [N];
    int ped_n = m_ped;
    int nxt   = m_dir;
    int np    = m_phase;
    for (int i = 0; i < N; i++) if (i != m_dir && m_pend[i]) others = 1'b1;
    case (m_phase)
      0:       leave = (done >= GMAX) || (done >= GMIN && (others || m_ped != 0));
      1:       leave = (done >= YC);
      2:       leave = (done >= ARC);
      default: leave = (done >= WC);
    endcase
    pend_n = m_pend;
    for (int i = 0; i < N; i++)
      if (car[i] && !(m_phase == 0 && m_dir == i)) pend_n[i] = 1'b1;
`ifdef PED_WALK_EN
    if (ped && m_phase != 3) ped_n = 1;
`else
    if (ped) ped_n = 0;
`endif
    if (leave) begin
      case (m_phase)
        0: np = 1;
        1: np = 2;
        2: if (m_ped != 0) np = 3; else begin np = 0; nxt = pick_next(); end
        default: begin np = 0; nxt = pick_next(); end
      endcase
      if (np == 0) pend_n[nxt] = 1'b0;
      if (np == 3) ped_n = 0;
    end
    m_phase = np;
    m_dir   = nxt;
    m_age   = leave ? 0 : done;
    m_pend  = pend_n;
    m_ped   = ped_n;
  endfunction

  task automatic compare_model();
    logic [2*N-1:0] e;
    e = '0;
    if (m_phase == 0)      e[2*m_dir +: 2] = 2'b01;
    else if (m_phase == 1) e[2*m_dir +: 2] = 2'b10;
    check("lights",     32'(bus.lights),     32'(e));
    check("active_dir", 32'(bus.active_dir), 32'(m_dir));
    check("walk",       32'(bus.walk),       32'(m_phase == 3));
  endtask

  task automatic cycle(input logic [N-1:0] car, input logic ped);
    bus.car_req = car;
    bus.ped_req = ped;
    @(posedge clk);
    model_step(car, ped);
    edge_no++;
    @(negedge clk);
    compare_model();
    if (m_phase != last_phase)
      $display("edge %0d: dir %0d enters %s", edge_no, m_dir, pname[m_phase]);
    last_phase = m_phase;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.car_req = '0;
    bus.ped_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    edge_no = 0;
    last_phase = 0;
    compare_model();
    $display("reset released: dir 0 GREEN");
  endtask

  // Reset asserted in the middle of a cycle must act without a clock edge.
  task automatic async_reset();
    #2;
    bus.car_req = '0;
    bus.ped_req = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_lights", 32'(bus.lights), 32'h01);
    check("async_rst_dir",    32'(bus.active_dir), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    edge_no = 0;
    last_phase = 0;
    compare_model();
    $display("async reset applied and released");
  endtask

  function automatic int green_dir();
    for (int i = 0; i < N; i++) if (bus.lights[2*i +: 2] == 2'b01) return i;
    return -1;
  endfunction

  initial begin
    logic [N-1:0] car;
    int order [2];
    int got;
    int prev;
    int bound;

    reset = 1'b1;
    bus.car_req = '0;
    bus.ped_req = 1'b0;

    // No requests: dir0 runs to GREEN_MAX, then dir1.
    do_reset();
    check("reset_lights", 32'(bus.lights), 32'h01);
    for (int e = 1; e <= 11; e++) begin
      cycle('0, 1'b0);
      if (e == 7)  check("idle_green7",  32'(bus.lights), 32'h01);
      if (e == 8)  check("idle_yellow8", 32'(bus.lights), 32'h02);
      if (e == 10) check("idle_allred10", 32'(bus.lights), 32'h00);
      if (e == 11) check("idle_dir1_11", 32'(bus.lights), 32'h04);
    end

    // car_req[2] at edge 1: early exit at GREEN_MIN, dir2 green at edge 6.
    do_reset();
    cycle(4'b0100, 1'b0);
    for (int e = 2; e <= 6; e++) begin
      cycle('0, 1'b0);
      if (e == 3) check("req2_yellow3", 32'(bus.lights), 32'h02);
      if (e == 5) check("req2_allred5", 32'(bus.lights), 32'h00);
      if (e == 6) check("req2_green6",  32'(bus.lights), 32'h10);
    end

    // While dir2 is green, request dirs 1 and 3: dir3 first, then dir1.
    cycle(4'b1010, 1'b0);
    order = '{-1, -1};
    got = 0;
    prev = 2;
    for (int c = 0; c < 60 && got < 2; c++) begin
      cycle('0, 1'b0);
      if (green_dir() >= 0 && green_dir() != prev) begin
        order[got] = green_dir();
        prev = green_dir();
        got++;
      end
    end
    check("rr_first",  32'(order[0]), 32'd3);
    check("rr_second", 32'(order[1]), 32'd1);

    // Own request held during green is ignored: full GREEN_MAX.
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      cycle(4'b0001, 1'b0);
      if (e == 7) check("own_req_green7",  32'(bus.lights), 32'h01);
      if (e == 8) check("own_req_yellow8", 32'(bus.lights), 32'h02);
    end
    for (int e = 9; e <= 11; e++) cycle('0, 1'b0);

    // Reset during dir3 yellow with dir1 pending: request must be lost.
    do_reset();
    cycle(4'b1000, 1'b0);
    bound = 0;
    while (!(m_phase == 1 && m_dir == 3) && bound < 40) begin
      cycle('0, 1'b0);
      bound++;
    end
    check("reach_dir3_yellow", 32'(bus.lights), 32'h80);
    cycle(4'b0010, 1'b0);
    async_reset();
    for (int e = 1; e <= 8; e++) begin
      cycle('0, 1'b0);
      if (e == 3) check("post_rst_green3",  32'(bus.lights), 32'h01);
      if (e == 8) check("post_rst_yellow8", 32'(bus.lights), 32'h02);
    end

    // Pedestrian request at edge 1.
    do_reset();
    cycle('0, 1'b1);
    for (int e = 2; e <= 10; e++) begin
      cycle('0, 1'b0);
`ifdef PED_WALK_EN
      if (e == 3)  check("ped_yellow3", 32'(bus.lights), 32'h02);
      if (e == 5)  check("ped_allred5", 32'(bus.lights), 32'h00);
      if (e == 6)  check("ped_walk6",   32'(bus.walk),   32'd1);
      if (e == 9)  check("ped_walk9",   32'(bus.walk),   32'd1);
      if (e == 10) check("ped_dir1_10", 32'(bus.lights), 32'h04);
      if (e == 10) check("ped_walk10",  32'(bus.walk),   32'd0);
`else
      if (e == 6) check("noped_walk6",   32'(bus.walk),   32'd0);
      if (e == 7) check("noped_green7",  32'(bus.lights), 32'h01);
      if (e == 8) check("noped_yellow8", 32'(bus.lights), 32'h02);
`endif
    end

    // Randomized requests and occasional resets against the model.
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) car[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) async_reset();
      else cycle(car, ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multiway_traffic_controller.md
# multiway_traffic_controller

Parametrised N-direction traffic-light controller with sensor-driven, round-robin phase selection, minimum/maximum green times, fixed yellow and all-red clearance intervals, and an optional pedestrian walk phase. It is the next-generation intersection controller. It sits directly on the lamp drivers and vehicle/pedestrian request inputs, and drives one 2-bit lamp code per direction.

## Interface
- NUM_DIR, 4: number of approach directions (2..8).
- GREEN_MIN, 3: minimum green length in cycles (>=1).
- GREEN_MAX, 8: maximum green length in cycles (>=GREEN_MIN).
- YELLOW_CYC, 2: yellow length in cycles (>=1).
- ALLRED_CYC, 1: all-red clearance length in cycles (>=1).
- WALK_CYC, 4: pedestrian walk length in cycles (>=1; used only with PED_WALK_EN).
- TIMER_W, 8: phase timer width; must hold max(all lengths)-1.
- clk  input  1  clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- car_req  input  NUM_DIR  per-direction vehicle sensor; any high cycle latches a request.
- ped_req  input  1  pedestrian button; any high cycle latches a request.
- lights  output  2*NUM_DIR  lamp code for direction i on bits [2i+1:2i]: RED=00, GREEN=01, YELLOW=10.
- active_dir  output  $clog2(NUM_DIR)  index of the direction currently green or yellow.
- walk  output  1  high during the WALK phase.

## Operation
- State machine has four states: GREEN, YELLOW, ALLRED, and WALK. The GREEN, YELLOW and ALLRED states apply to active_dir.
- lights are decoded combinationally from the state and active_dir.
  - GREEN: active_dir is 01 and all others are 00.
  - YELLOW: active_dir is 10 and all others are 00.
  - ALLRED and WALK: all directions are 00.
- pending[NUM_DIR-1:0]:
  - Bit i is set by car_req[i]. While dir i is GREEN, car_req[i] is ignored.
  - Bit i is cleared on entry to GREEN for dir i. If a request for dir i arrives on that same edge, the clear wins.
- GREEN exit:
  - Leave when timer reaches GREEN_MIN-1 and any other pending bit is set, or the ped request is set.
  - Otherwise leave when timer reaches GREEN_MAX-1.
  - A request arriving after GREEN_MIN causes exit on the next edge.
- YELLOW lasts YELLOW_CYC cycles, then the controller goes to ALLRED.
- ALLRED lasts ALLRED_CYC cycles. On exit:
  - If a ped request is latched (macro on), go to WALK.
  - Otherwise go to GREEN for the next direction.
- Next direction is the first pending index after active_dir, searching upward with wrap-around. If nothing is pending, it is (active_dir+1) mod NUM_DIR. It is evaluated on the ALLRED/WALK exit edge.
- The timer resets to 0 on every state entry and increments once per cycle.

## Timing
- Reset values: GREEN state, active_dir=0, timer=0, pending=0, ped latch=0, walk=0. lights show dir 0 GREEN and all others RED.
- A phase of length L occupies exactly L clock periods. Example: the GREEN→YELLOW change happens on edge GREEN_MIN or GREEN_MAX, counted from the edge that entered GREEN or from reset release.
- Latency from a request to green is at least YELLOW_CYC+ALLRED_CYC cycles after the GREEN exit condition is met.
- Reset asserted mid-phase immediately forces the reset values. Latched requests are lost.
- A request that is asserted for multiple cycles counts as one request.

## Configuration
- PED_WALK_EN, when defined:
  - ped_req is latched. The latch is ignored while in WALK and cleared on WALK entry.
  - The latched request forces GREEN exit after GREEN_MIN.
  - WALK is inserted after ALLRED, lasting WALK_CYC cycles with walk=1 and all lights RED.
  - After WALK, the controller selects the next direction.
- When not defined:
  - The ports still exist.
  - ped_req is ignored, walk is tied to 0, and the WALK state is unreachable.

## Structure
- Shared package traffic_pkg holds the light encodings RED/GREEN/YELLOW and the phase-state encoding.
- One sub-module, rr_next_dir: a combinational round-robin picker. Inputs are pending and the current index; output is the next index.

## Test plan
(Parameters at defaults; edges are counted from reset release.)
- No requests: dir0 GREEN edges 0–7, YELLOW on edge 8, ALLRED on edge 10, dir1 GREEN on edge 11.
- car_req[2] pulsed at edge 1: dir0 YELLOW on edge 3, ALLRED on edge 5, dir2 GREEN on edge 6. pending[2] is cleared on edge 6.
- While dir2 is GREEN, pulse car_req[1] and car_req[3] together: dir3 is served next, then dir1 (wrap-around).
- Hold car_req[0] high throughout dir0 GREEN: it is ignored, and dir0 still runs to GREEN_MAX (8 cycles).
- Assert reset during YELLOW of dir3: lights immediately show dir0 GREEN, and pending is cleared.
- PED_WALK_EN, ped_req pulsed at edge 1: YELLOW on edge 3, ALLRED on edge 5, walk=1 on edges 6–9, dir1 GREEN on edge 10. Without the macro, walk stays 0 and dir0 holds GREEN for 8 cycles.
